stage_4_mem: RTL and testbench
==============================

Name: stage_4_mem

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline, directly upstream of the write-back stage.
- Takes the execute-stage result, performs loads and stores over a req/ack data-memory port with variable latency, and aligns and extends load data.
- Drives the MEM/WB pipeline register that write-back consumes: mem data, rd number, ALU result, op type.
- Stalls upstream while a memory access is outstanding.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT before the access is aborted with o_bus_err (range 1..255)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
i_valid  input  1  an instruction from execute is present this cycle
i_alu_out  input  32  ALU result; the effective address for memory ops
i_rs2  input  32  store data
i_rd_num  input  5  destination register
i_funct3  input  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
i_mem_read  input  1  load
i_mem_write  input  1  store
o_stall  output  1  upstream must hold its inputs
dmem_req  output  1  memory request, registered
dmem_we  output  1  write request
dmem_addr  output  32  word address, {i_alu_out[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_ack  input  1  one-cycle completion pulse
dmem_rdata  input  32  read word, valid with dmem_ack
o_valid  output  1  MEM/WB register holds a retiring instruction
o_mem_out  output  32  aligned/extended load data
o_rd_num  output  5  destination register; 0 for stores, faults, bubbles
o_alu_out  output  32  registered i_alu_out
o_op_type  output  1  0 = select ALU result, 1 = select mem data
o_misaligned  output  1  one-cycle fault flag
o_bus_err  output  1  one-cycle timeout flag

Behaviour:
- Reset: FSM=IDLE; all registered outputs 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, o_valid, o_mem_out, o_rd_num, o_alu_out, o_op_type, o_misaligned, o_bus_err); counter=0.
- FSM states: IDLE, WAIT.
- Mem op = i_mem_read | i_mem_write. If both are set, it is a read.
- Misaligned when halfword and addr[0]=1, or word and addr[1:0]!=0.

IDLE, i_valid=1:
- Non-mem op: next cycle o_valid=1, o_op_type=0, o_alu_out and o_rd_num copied from inputs. Latency 1.
- Misaligned mem op: no request issued; next cycle o_valid=1, o_rd_num=0, o_misaligned=1.
- Aligned mem op: latch the request, go to WAIT, dmem_req=1 from the next cycle. o_valid is 0 in the issue cycle.

IDLE, i_valid=0:
- o_valid=0 next cycle (bubble).

o_stall:
- Combinational; 1 when (IDLE & i_valid & aligned mem op) or (WAIT & !dmem_ack).

Store lanes:
- SB: be=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
- SH: be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}.
- SW: be=1111, wdata=rs2.

Load extract:
- Byte lane is dmem_rdata[8*addr[1:0]+:8].
- Halfword lane is dmem_rdata[16*addr[1]+:16].
- LB/LH sign-extend; LBU/LHU zero-extend.

WAIT:
- dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable; the counter increments each cycle.
- On dmem_ack: dmem_req=0 next cycle, return to IDLE, o_valid=1 next cycle.
  - Load: o_op_type=1, o_mem_out=extracted data, o_rd_num=latched rd.
  - Store: o_op_type=0, o_rd_num=0.
- Ack in the first WAIT cycle gives a load-to-o_valid latency of 2.
- If counter reaches TIMEOUT without ack: abort, dmem_req=0, return to IDLE; next cycle o_valid=1, o_rd_num=0, o_bus_err=1.
- Ack in the same cycle as the timeout is treated as an ack.

Other rules:
- o_misaligned and o_bus_err are single-cycle pulses.
- An ack arriving while in IDLE is ignored.
- rst asserted during WAIT: IDLE next cycle, dmem_req=0, pending access dropped, no o_valid.
- The counter clears on entry to WAIT.

Test Plan:
- ALU op, alu_out=0x1234, rd=5 -> next cycle o_valid=1, o_op_type=0, o_alu_out=0x1234, o_rd_num=5, o_stall never high.
- LB at addr 0x103, ack after 3 WAIT cycles with rdata=0x80FF_0000 -> dmem_addr=0x100, o_stall high 4 cycles, o_mem_out=0xFFFF_FF80, o_op_type=1.
- LHU at 0x102, rdata=0x8001_0000 -> o_mem_out=0x0000_8001; LW at 0x101 -> no dmem_req, o_misaligned pulse, o_rd_num=0.
- SB at 0x202, rs2=0xAB -> dmem_be=0100, dmem_wdata=0xABAB_ABAB, dmem_we=1; after ack o_rd_num=0, o_op_type=0.
- LW with ack never arriving, TIMEOUT=4 -> dmem_req drops after 4 WAIT cycles, o_bus_err pulse, then a late ack is ignored.
- rst pulse in the second WAIT cycle -> dmem_req=0 and o_valid=0 next cycle; the following ALU op retires normally.

Source files
------------

// File: rtl/stage_4_mem.sv
// Memory-access stage: issues loads/stores on a req/ack data port, aligns load data,
// and drives the MEM/WB register consumed by write-back.
module stage_4_mem #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs2,
  input  logic [4:0]  i_rd_num,
  input  logic [2:0]  i_funct3,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  output logic        o_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        o_valid,
  output logic [31:0] o_mem_out,
  output logic [4:0]  o_rd_num,
  output logic [31:0] o_alu_out,
  output logic        o_op_type,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [1:0]  r_off;
  logic [31:0] r_alu;

  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_issue;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_mem_op     = i_mem_read | i_mem_write;
  assign w_misaligned = ((i_funct3[1:0] == 2'b01) && i_alu_out[0]) ||
                        ((i_funct3[1:0] == 2'b10) && (i_alu_out[1:0] != 2'b00));
  assign w_issue      = (r_state == StIdle) && i_valid && w_mem_op && !w_misaligned;
  // An ack in the last allowed cycle wins over the timeout.
  assign w_timeout    = (r_state == StWait) && !dmem_ack && (r_cnt == TimeoutLast);
  assign o_stall      = w_issue || ((r_state == StWait) && !dmem_ack);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_issue) begin
          w_state_nxt = StWait;
          w_cnt_nxt   = 8'd0;
        end
      end
      StWait: begin
        if (dmem_ack || w_timeout) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_rs2;
    case (i_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << i_alu_out[1:0];
        w_wdata = {4{i_rs2[7:0]}};
      end
      2'b01: begin
        w_be    = i_alu_out[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_rs2[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      2'd3:    w_byte = dmem_rdata[31:24];
      default: w_byte = dmem_rdata[7:0];
    endcase
    w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    // funct3[2] set means unsigned (LBU/LHU).
    case (r_funct3[1:0])
      2'b00:   w_load = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_funct3[2] & w_half[15]}}, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_wdata   <= 32'd0;
      dmem_be      <= 4'd0;
      o_valid      <= 1'b0;
      o_mem_out    <= 32'd0;
      o_rd_num     <= 5'd0;
      o_alu_out    <= 32'd0;
      o_op_type    <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
      r_is_load    <= 1'b0;
      r_funct3     <= 3'd0;
      r_rd         <= 5'd0;
      r_off        <= 2'd0;
      r_alu        <= 32'd0;
    end else begin
      o_valid      <= 1'b0;
      o_rd_num     <= 5'd0;
      o_op_type    <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_valid && !w_mem_op) begin
            o_valid   <= 1'b1;
            o_alu_out <= i_alu_out;
            o_rd_num  <= i_rd_num;
          end else if (i_valid && w_misaligned) begin
            o_valid      <= 1'b1;
            o_misaligned <= 1'b1;
            o_alu_out    <= i_alu_out;
          end else if (w_issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= i_mem_write & ~i_mem_read;
            dmem_addr  <= {i_alu_out[31:2], 2'b00};
            dmem_wdata <= w_wdata;
            dmem_be    <= w_be;
            r_is_load  <= i_mem_read;
            r_funct3   <= i_funct3;
            r_rd       <= i_rd_num;
            r_off      <= i_alu_out[1:0];
            r_alu      <= i_alu_out;
          end
        end
        StWait: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            o_valid   <= 1'b1;
            o_alu_out <= r_alu;
            if (r_is_load) begin
              o_op_type <= 1'b1;
              o_mem_out <= w_load;
              o_rd_num  <= r_rd;
            end
          end else if (w_timeout) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            o_valid   <= 1'b1;
            o_bus_err <= 1'b1;
            o_alu_out <= r_alu;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_4_mem.sv
// Directed bench for stage_4_mem with TIMEOUT=4 and hand-computed expectations.
module tb_stage_4_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_alu_out;
  logic [31:0] i_rs2;
  logic [4:0]  i_rd_num;
  logic [2:0]  i_funct3;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        o_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        o_valid;
  logic [31:0] o_mem_out;
  logic [4:0]  o_rd_num;
  logic [31:0] o_alu_out;
  logic        o_op_type;
  logic        o_misaligned;
  logic        o_bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  stage_4_mem #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_alu_out    (i_alu_out),
    .i_rs2        (i_rs2),
    .i_rd_num     (i_rd_num),
    .i_funct3     (i_funct3),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .o_stall      (o_stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .o_valid      (o_valid),
    .o_mem_out    (o_mem_out),
    .o_rd_num     (o_rd_num),
    .o_alu_out    (o_alu_out),
    .o_op_type    (o_op_type),
    .o_misaligned (o_misaligned),
    .o_bus_err    (o_bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    i_valid     = 1'b0;
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
    i_alu_out   = 32'd0;
    i_rs2       = 32'd0;
    i_rd_num    = 5'd0;
    i_funct3    = 3'd0;
  endtask

  // Presents one instruction for a single cycle; returns o_stall seen in that cycle.
  task automatic issue(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic rd_en, input logic wr_en,
                       output int stalls);
    i_valid     = 1'b1;
    i_funct3    = f3;
    i_alu_out   = addr;
    i_rs2       = rs2;
    i_rd_num    = rd;
    i_mem_read  = rd_en;
    i_mem_write = wr_en;
    #1;
    stalls = int'(o_stall);
    tick();
    bubble();
  endtask

  // Holds off ack for 'waits' WAIT cycles, then acks with rdata; accumulates stall cycles.
  task automatic complete(input int waits, input logic [31:0] rdata, inout int stalls);
    dmem_ack = 1'b0;
    for (int k = 0; k < waits; k++) begin
      stalls += int'(o_stall);
      tick();
    end
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    #1;
    stalls += int'(o_stall);
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
  endtask

  initial begin
    int st;
    int n;
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    bubble();
    tick();
    tick();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_rd", 32'(o_rd_num), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    rst = 1'b0;

    // ALU op retires after one cycle without stalling
    issue(3'b000, 32'h1234, 32'd0, 5'd5, 1'b0, 1'b0, st);
    check("alu_stall", 32'(st), 32'd0);
    check("alu_valid", 32'(o_valid), 32'd1);
    check("alu_op_type", 32'(o_op_type), 32'd0);
    check("alu_out", o_alu_out, 32'h1234);
    check("alu_rd", 32'(o_rd_num), 32'd5);
    tick();
    check("bubble_valid", 32'(o_valid), 32'd0);
    check("bubble_rd", 32'(o_rd_num), 32'd0);

    // LB at 0x103: ack on the 4th WAIT cycle, coinciding with the timeout boundary
    issue(3'b000, 32'h103, 32'd0, 5'd7, 1'b1, 1'b0, st);
    check("lb_req", 32'(dmem_req), 32'd1);
    check("lb_addr", dmem_addr, 32'h100);
    check("lb_we", 32'(dmem_we), 32'd0);
    check("lb_issue_valid", 32'(o_valid), 32'd0);
    complete(3, 32'h80FF_0000, st);
    check("lb_stall_cycles", 32'(st), 32'd4);
    check("lb_valid", 32'(o_valid), 32'd1);
    check("lb_op_type", 32'(o_op_type), 32'd1);
    check("lb_mem_out", o_mem_out, 32'hFFFF_FF80);
    check("lb_rd", 32'(o_rd_num), 32'd7);
    check("lb_req_drop", 32'(dmem_req), 32'd0);

    // LHU at 0x102, immediate ack: latency 2
    issue(3'b101, 32'h102, 32'd0, 5'd8, 1'b1, 1'b0, st);
    complete(0, 32'h8001_0000, st);
    check("lhu_stall_cycles", 32'(st), 32'd1);
    check("lhu_valid", 32'(o_valid), 32'd1);
    check("lhu_mem_out", o_mem_out, 32'h0000_8001);

    // LH at 0x102 sign-extends the same lane
    issue(3'b001, 32'h102, 32'd0, 5'd8, 1'b1, 1'b0, st);
    complete(1, 32'h8001_0000, st);
    check("lh_mem_out", o_mem_out, 32'hFFFF_8001);

    // LBU at 0x101 and LW at 0x104
    issue(3'b100, 32'h101, 32'd0, 5'd6, 1'b1, 1'b0, st);
    complete(0, 32'h1234_F0AA, st);
    check("lbu_mem_out", o_mem_out, 32'h0000_00F0);
    issue(3'b010, 32'h104, 32'd0, 5'd4, 1'b1, 1'b0, st);
    check("lw_addr", dmem_addr, 32'h104);
    complete(2, 32'hDEAD_BEEF, st);
    check("lw_mem_out", o_mem_out, 32'hDEAD_BEEF);
    check("lw_rd", 32'(o_rd_num), 32'd4);

    // Misaligned LW: no request, one-cycle fault pulse
    issue(3'b010, 32'h101, 32'd0, 5'd9, 1'b1, 1'b0, st);
    check("mis_stall", 32'(st), 32'd0);
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_valid", 32'(o_valid), 32'd1);
    check("mis_flag", 32'(o_misaligned), 32'd1);
    check("mis_rd", 32'(o_rd_num), 32'd0);
    tick();
    check("mis_pulse", 32'(o_misaligned), 32'd0);
    issue(3'b001, 32'h103, 32'd0, 5'd9, 1'b1, 1'b0, st);
    check("mis_lh_flag", 32'(o_misaligned), 32'd1);

    // Stores: lane enables and replicated data
    issue(3'b000, 32'h202, 32'h0000_00AB, 5'd3, 1'b0, 1'b1, st);
    check("sb_be", 32'(dmem_be), 32'h4);
    check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    check("sb_we", 32'(dmem_we), 32'd1);
    check("sb_addr", dmem_addr, 32'h200);
    complete(1, 32'd0, st);
    check("sb_valid", 32'(o_valid), 32'd1);
    check("sb_rd", 32'(o_rd_num), 32'd0);
    check("sb_op_type", 32'(o_op_type), 32'd0);
    issue(3'b001, 32'h206, 32'h1234_CDEF, 5'd3, 1'b0, 1'b1, st);
    check("sh_be", 32'(dmem_be), 32'hC);
    check("sh_wdata", dmem_wdata, 32'hCDEF_CDEF);
    complete(0, 32'd0, st);
    issue(3'b010, 32'h208, 32'hCAFE_F00D, 5'd3, 1'b0, 1'b1, st);
    check("sw_be", 32'(dmem_be), 32'hF);
    check("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
    complete(0, 32'd0, st);

    // Read+write together is a read
    issue(3'b010, 32'h20C, 32'h0, 5'd2, 1'b1, 1'b1, st);
    check("rw_we", 32'(dmem_we), 32'd0);
    complete(0, 32'h0000_0042, st);
    check("rw_rd", 32'(o_rd_num), 32'd2);

    // Timeout: request held exactly 4 WAIT cycles, then bus error; late ack ignored
    issue(3'b010, 32'h300, 32'd0, 5'd11, 1'b1, 1'b0, st);
    n = 0;
    while (dmem_req && n < 20) begin
      n++;
      tick();
    end
    check("to_wait_cycles", 32'(n), 32'd4);
    check("to_bus_err", 32'(o_bus_err), 32'd1);
    check("to_valid", 32'(o_valid), 32'd1);
    check("to_rd", 32'(o_rd_num), 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_5555;
    tick();
    dmem_ack   = 1'b0;
    check("late_ack_valid", 32'(o_valid), 32'd0);
    check("late_ack_err", 32'(o_bus_err), 32'd0);
    check("late_ack_req", 32'(dmem_req), 32'd0);

    // Reset in the second WAIT cycle drops the access
    issue(3'b010, 32'h400, 32'd0, 5'd12, 1'b1, 1'b0, st);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_req", 32'(dmem_req), 32'd0);
    check("rstw_valid", 32'(o_valid), 32'd0);
    issue(3'b000, 32'h55, 32'd0, 5'd10, 1'b0, 1'b0, st);
    check("post_rst_stall", 32'(st), 32'd0);
    check("post_rst_valid", 32'(o_valid), 32'd1);
    check("post_rst_rd", 32'(o_rd_num), 32'd10);
    check("post_rst_alu", o_alu_out, 32'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
